// File: rtl/rx9_align10.sv
// Nine-lane 10-bit word aligner: per-lane training-pattern search over a 20-bit sliding window.
// Optional per-lane payload error counters are built when RX9_ERR_CNT_EN is defined.
module rx9_align10 #(
  parameter logic [9:0]  TRAIN_PATTERN = 10'h0F8,
  parameter int unsigned MATCH_COUNT   = 16
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_rx_locked,
  input  logic        I_realign,
  input  logic        I_train,
  input  logic [9:0]  i0_p,
  input  logic [9:0]  i1_p,
  input  logic [9:0]  i2_p,
  input  logic [9:0]  i3_p,
  input  logic [9:0]  i4_p,
  input  logic [9:0]  i5_p,
  input  logic [9:0]  i6_p,
  input  logic [9:0]  i7_p,
  input  logic [9:0]  i8_p,
  output logic [9:0]  o0_p,
  output logic [9:0]  o1_p,
  output logic [9:0]  o2_p,
  output logic [9:0]  o3_p,
  output logic [9:0]  o4_p,
  output logic [9:0]  o5_p,
  output logic [9:0]  o6_p,
  output logic [9:0]  o7_p,
  output logic [9:0]  o8_p,
  output logic [8:0]  O_lane_aligned,
  output logic [35:0] O_offsets,
  output logic        O_locked
`ifdef RX9_ERR_CNT_EN
  ,
  output logic [71:0] O_err_cnt
`endif
);

  localparam int         Lanes   = 9;
  localparam logic [7:0] LastCnt = 8'(MATCH_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StSearch, StAligned} state_e;

  logic [9:0]       din      [Lanes];
  logic [9:0]       sel      [Lanes];
  logic [9:0]       prev_q   [Lanes];
  logic [9:0]       dout_q   [Lanes];
  logic [3:0]       off_q    [Lanes];
  logic [7:0]       cnt_q    [Lanes];
  state_e           state_q  [Lanes];
  logic [Lanes-1:0] holdoff_q;
  logic [Lanes-1:0] aligned_q;

  assign din[0] = i0_p;
  assign din[1] = i1_p;
  assign din[2] = i2_p;
  assign din[3] = i3_p;
  assign din[4] = i4_p;
  assign din[5] = i5_p;
  assign din[6] = i6_p;
  assign din[7] = i7_p;
  assign din[8] = i8_p;

  // Newer word sits above the previous one, so offset n takes the top n bits from din.
  always_comb begin
    for (int n = 0; n < Lanes; n++) begin
      sel[n] = 10'({din[n], prev_q[n]} >> off_q[n]);
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      for (int n = 0; n < Lanes; n++) begin
        prev_q[n] <= '0;
        dout_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < Lanes; n++) begin
        prev_q[n] <= din[n];
        dout_q[n] <= sel[n];
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      holdoff_q <= '0;
      aligned_q <= '0;
      for (int n = 0; n < Lanes; n++) begin
        state_q[n] <= StIdle;
        off_q[n]   <= '0;
        cnt_q[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < Lanes; n++) begin
        if (!I_rx_locked) begin
          state_q[n]   <= StIdle;
          cnt_q[n]     <= '0;
          holdoff_q[n] <= 1'b0;
          aligned_q[n] <= 1'b0;
        end else if (I_realign && state_q[n] != StIdle) begin
          // Offset is kept so a realign restarts from the last known-good position.
          state_q[n]   <= StSearch;
          cnt_q[n]     <= '0;
          holdoff_q[n] <= 1'b1;
          aligned_q[n] <= 1'b0;
        end else begin
          unique case (state_q[n])
            StIdle: begin
              cnt_q[n]     <= '0;
              holdoff_q[n] <= 1'b0;
              aligned_q[n] <= 1'b0;
              if (I_train) state_q[n] <= StSearch;
            end
            StSearch: begin
              if (I_train) begin
                // After an offset step the output register still holds the old alignment.
                if (holdoff_q[n]) begin
                  holdoff_q[n] <= 1'b0;
                end else if (dout_q[n] == TRAIN_PATTERN) begin
                  cnt_q[n] <= cnt_q[n] + 8'd1;
                  if (cnt_q[n] == LastCnt) begin
                    state_q[n]   <= StAligned;
                    aligned_q[n] <= 1'b1;
                  end
                end else begin
                  cnt_q[n]     <= '0;
                  off_q[n]     <= (off_q[n] == 4'd9) ? 4'd0 : off_q[n] + 4'd1;
                  holdoff_q[n] <= 1'b1;
                end
              end
            end
            StAligned: aligned_q[n] <= 1'b1;
            default:   state_q[n] <= StIdle;
          endcase
        end
      end
    end
  end

`ifdef RX9_ERR_CNT_EN
  logic [7:0] err_q [Lanes];

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      for (int n = 0; n < Lanes; n++) err_q[n] <= '0;
    end else begin
      for (int n = 0; n < Lanes; n++) begin
        if (!I_rx_locked || I_realign) begin
          err_q[n] <= '0;
        end else if (state_q[n] == StAligned && I_train && dout_q[n] != TRAIN_PATTERN &&
                     err_q[n] != 8'hFF) begin
          err_q[n] <= err_q[n] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    O_err_cnt = '0;
    for (int n = 0; n < Lanes; n++) O_err_cnt[8*n +: 8] = err_q[n];
  end
`endif

  assign o0_p = dout_q[0];
  assign o1_p = dout_q[1];
  assign o2_p = dout_q[2];
  assign o3_p = dout_q[3];
  assign o4_p = dout_q[4];
  assign o5_p = dout_q[5];
  assign o6_p = dout_q[6];
  assign o7_p = dout_q[7];
  assign o8_p = dout_q[8];

  always_comb begin
    O_offsets = '0;
    for (int n = 0; n < Lanes; n++) O_offsets[4*n +: 4] = off_q[n];
  end

  assign O_lane_aligned = aligned_q;
  assign O_locked       = I_rx_locked & (&aligned_q);

endmodule

// File: doc/rx9_align10.md
Name: rx9_align10

Overview:
- Receive-side counterpart of the 9-lane 10:1 LVDS transmit path.
- Takes 9 lanes of 10-bit parallel words from the LVDS receiver's core-clock domain.
- Runs a per-lane word-alignment search in fabric, using a rotation-unique training pattern and a 20-bit sliding window.
- Delivers aligned words, per-lane alignment flags and an overall lock to the link layer.

Parameters:
- TRAIN_PATTERN, 10'h0F8: training word the transmitter sends on every lane while training. All 10 rotations are distinct.
- MATCH_COUNT, 16: consecutive matches required to declare a lane aligned (range 2..255).

Ports:
- I_clk  input  1  receiver core clock; all logic is on this clock.
- I_rst  input  1  asynchronous, active-high reset.
- I_rx_locked  input  1  receiver PLL locked.
- I_realign  input  1  single-cycle pulse that restarts the search on all lanes.
- I_train  input  1  transmitter is sending TRAIN_PATTERN (link-layer sideband).
- i0_p..i8_p  input  10 each  raw deserialized lane words.
- o0_p..o8_p  output  10 each  aligned lane words.
- O_lane_aligned  output  9  per-lane aligned flag; bit n corresponds to lane n.
- O_offsets  output  36  current bit offset per lane, 4 bits each; lane n in [4n+3:4n], range 0..9.
- O_locked  output  1  I_rx_locked AND all 9 bits of O_lane_aligned.

Behaviour:
- Reset: all outputs 0, all offsets 0, all lane FSMs in IDLE, prev-word registers 0.
- Datapath, per lane:
  - prev <= in every cycle.
  - window = {in, prev} (20 bits).
  - o <= window[off+9:off].
  - Latency is 1 cycle from input word to output.
  - off is 0..9; values 10..15 are never produced.
- Each lane runs an independent FSM with a match counter cnt (8 bits) and a holdoff bit.
- IDLE:
  - cnt=0, holdoff=0, aligned=0.
  - Go to SEARCH when I_rx_locked=1 and I_train=1.
- SEARCH:
  - If holdoff=1: clear it and skip the compare this cycle (the output register still reflects the old offset).
  - Otherwise compare o against TRAIN_PATTERN.
  - Match: cnt++. When cnt reaches MATCH_COUNT-1 and another match arrives, go to ALIGNED and set aligned=1.
  - Mismatch: cnt=0, off <= (off==9) ? 0 : off+1, holdoff=1.
  - I_train=0 while in SEARCH: stay in SEARCH, no compare, cnt frozen.
- ALIGNED:
  - off is frozen and aligned=1.
  - Data passes through with no checking; payload may differ from the pattern.
- Global conditions, applied to all lanes; priority order is reset > I_rx_locked=0 > I_realign:
  - I_rx_locked falls in any state: next cycle aligned=0, FSM=IDLE, off retained.
  - I_realign=1: next cycle every lane goes to SEARCH with cnt=0, holdoff=1, aligned=0, off retained.
  - I_realign during IDLE is ignored.
- Search termination:
  - Offset wrap 9->0 is unlimited; the search continues until a match run completes.
  - A mismatch on the final compare resets cnt; no partial credit is kept.
- O_locked is a combinational AND of registered flags, so it updates in the same cycle as O_lane_aligned.

Optional Feature:
- Macro: RX9_ERR_CNT_EN.
- When defined:
  - Adds output O_err_cnt (72 bits, 8 per lane; lane n in [8n+7:8n]).
  - In ALIGNED with I_train=1, each o != TRAIN_PATTERN increments that lane's counter, saturating at 255.
  - Counters clear on reset, on I_realign, and on entry to IDLE.
- When undefined: the port and all counter logic are absent; the rest of the behaviour is identical.

Test Plan:
- Lanes 0..8 fed TRAIN_PATTERN pre-rotated by n bits (lane n rotated by n), I_train=1, I_rx_locked=1:
  - each lane reaches O_offsets lane field = the offset that yields 10'h0F8;
  - all O_lane_aligned bits set;
  - O_locked=1 within 10*(MATCH_COUNT+2)+2 cycles.
- Aligned lane 3, then a single corrupt input word:
  - O_lane_aligned[3] stays 1 and the offset is unchanged.
  - With RX9_ERR_CNT_EN, lane-3 O_err_cnt = 1; 300 corrupt words saturate it at 255.
- Lane at offset 7 with 15 matches, then one mismatch:
  - cnt clears and offset becomes 8; the following cycle is skipped (holdoff); alignment is not declared.
- Offset 9 with a mismatch:
  - offset wraps to 0 and the search continues.
- Locked link, I_rx_locked dropped for 1 cycle:
  - O_locked=0 and O_lane_aligned=0 the next cycle;
  - on relock with I_train=1, realignment completes at the retained offsets within MATCH_COUNT+2 cycles.
- I_realign pulse while locked, simultaneous with I_rx_locked=0:
  - all lanes go to IDLE (lock loss has priority);
  - I_rst asserted mid-SEARCH clears all outputs immediately (asynchronously).
